// File: rtl/mpu_alu_arb_if.sv
// Signal bundle between the MPU check engines, the shared-ALU arbiter and the ALU.
// Requesters use master, the arbiter uses slave, the ALU instance uses alu.
interface mpu_alu_arb_if #(
    parameter int N  = 4,
    parameter int IW = 2
);
    logic [N-1:0]      req;
    logic [2*N-1:0]    req_size;
    logic [4*N-1:0]    req_op;
    logic [64*N-1:0]   req_a;
    logic [64*N-1:0]   req_b;
    logic [64*N-1:0]   req_m0;
    logic [64*N-1:0]   req_m1;
    logic [N-1:0]      ack;
    logic [63:0]       res;
    logic [7:0]        flags;
    logic              busy;
    logic [IW-1:0]     gnt_id;
    logic [1:0]        alu_size;
    logic [3:0]        alu_op;
    logic [63:0]       alu_a;
    logic [63:0]       alu_b;
    logic [63:0]       alu_m0;
    logic [63:0]       alu_m1;
    logic [63:0]       alu_res;
    logic [7:0]        alu_flags;

    modport slave (
        input  req, req_size, req_op, req_a, req_b, req_m0, req_m1,
        output ack, res, flags, busy, gnt_id,
        output alu_size, alu_op, alu_a, alu_b, alu_m0, alu_m1,
        input  alu_res, alu_flags
    );

    modport master (
        output req, req_size, req_op, req_a, req_b, req_m0, req_m1,
        input  ack, res, flags, busy, gnt_id
    );

    modport alu (
        input  alu_size, alu_op, alu_a, alu_b, alu_m0, alu_m1,
        output alu_res, alu_flags
    );
endinterface

// File: rtl/mpu_alu_arb.sv
// Round-robin arbiter sharing one combinational MPU check ALU among N requesters.
// Each operation runs IDLE (grant + operand capture) -> EXEC (ALU settles) -> ACK (one-cycle pulse).
module mpu_alu_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    mpu_alu_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [63:0]   res_q, res_d;
    logic [7:0]    flags_q, flags_d;
    logic [1:0]    alu_size_q, alu_size_d;
    logic [3:0]    alu_op_q, alu_op_d;
    logic [63:0]   alu_a_q, alu_a_d;
    logic [63:0]   alu_b_q, alu_b_d;
    logic [63:0]   alu_m0_q, alu_m0_d;
    logic [63:0]   alu_m1_q, alu_m1_d;

    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;

    // Scan starts one past the last grantee and wraps at N, so every held req wins within N rounds.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = last_q;
        for (int off = 0; off < N; off++) begin
            cand = (cand == IW'(N - 1)) ? '0 : cand + IW'(1);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_id_d   = gnt_id_q;
        ack_d      = '0;
        res_d      = res_q;
        flags_d    = flags_q;
        alu_size_d = alu_size_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_m0_d   = alu_m0_q;
        alu_m1_d   = alu_m1_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_id_d = win;
                    for (int i = 0; i < N; i++) begin
                        if (IW'(i) == win) begin
                            alu_size_d = bus.req_size[2*i +: 2];
                            alu_op_d   = bus.req_op[4*i +: 4];
                            alu_a_d    = bus.req_a[64*i +: 64];
                            alu_b_d    = bus.req_b[64*i +: 64];
                            alu_m0_d   = bus.req_m0[64*i +: 64];
                            alu_m1_d   = bus.req_m1[64*i +: 64];
                        end
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d            = bus.alu_res;
                flags_d          = bus.alu_flags;
                ack_d[gnt_id_q]  = 1'b1;
                last_d           = gnt_id_q;
                // Parking the ALU on op 0 keeps its result at zero outside evaluation.
                alu_op_d         = '0;
                state_d          = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            last_q     <= IW'(N - 1);
            gnt_id_q   <= '0;
            ack_q      <= '0;
            res_q      <= '0;
            flags_q    <= '0;
            alu_size_q <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_m0_q   <= '0;
            alu_m1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_id_q   <= gnt_id_d;
            ack_q      <= ack_d;
            res_q      <= res_d;
            flags_q    <= flags_d;
            alu_size_q <= alu_size_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_m0_q   <= alu_m0_d;
            alu_m1_q   <= alu_m1_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.res      = res_q;
    assign bus.flags    = flags_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.gnt_id   = gnt_id_q;
    assign bus.alu_size = alu_size_q;
    assign bus.alu_op   = alu_op_q;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_m0   = alu_m0_q;
    assign bus.alu_m1   = alu_m1_q;
endmodule

// File: tb/tb_mpu_alu_arb.sv
// Directed bench for mpu_alu_arb with a small behavioural check ALU attached.
// ALU: op1 mask test, op2 masked equality, op3 unsigned less-than, all at the width chosen by size.
module tb_mpu_alu_arb;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mpu_alu_arb_if #(.N(N), .IW(IW)) bus ();

    mpu_alu_arb #(.N(N), .IW(IW)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] width_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    logic [63:0] wm;
    logic        hit;
    always_comb begin
        wm  = width_mask(bus.alu_size);
        hit = 1'b0;
        case (bus.alu_op)
            4'd1: hit = ((bus.alu_a & bus.alu_m0 & wm) == 64'd0) &&
                        ((bus.alu_a & bus.alu_m1 & wm) == (bus.alu_m1 & wm));
            4'd2: hit = (((bus.alu_a ^ bus.alu_b) & bus.alu_m0 & wm) == 64'd0);
            4'd3: hit = ((bus.alu_a & wm) < (bus.alu_b & wm));
            default: hit = 1'b0;
        endcase
        bus.alu_res   = {63'd0, hit};
        bus.alu_flags = (bus.alu_op >= 4'd1 && bus.alu_op <= 4'd3) ? {hit, 3'b000, bus.alu_op} : 8'h00;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [1:0] size, input logic [3:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] m0, input logic [63:0] m1);
        bus.req_size[2*i +: 2] = size;
        bus.req_op[4*i +: 4]   = op;
        bus.req_a[64*i +: 64]  = a;
        bus.req_b[64*i +: 64]  = b;
        bus.req_m0[64*i +: 64] = m0;
        bus.req_m1[64*i +: 64] = m1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b exp %b", bus.ack, 4'b0000); end
        checks++; if (bus.res !== 64'd0) begin errors++; $display("FAIL reset_res got %h exp %h", bus.res, 64'd0); end
        checks++; if (bus.flags !== 8'h00) begin errors++; $display("FAIL reset_flags got %h exp %h", bus.flags, 8'h00); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp %b", bus.busy, 1'b0); end
        checks++; if (bus.gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt got %0d exp %0d", bus.gnt_id, 0); end
        checks++; if (bus.alu_op !== 4'd0) begin errors++; $display("FAIL reset_alu_op got %0d exp %0d", bus.alu_op, 0); end
        checks++; if (bus.alu_a !== 64'd0) begin errors++; $display("FAIL reset_alu_a got %h exp %h", bus.alu_a, 64'd0); end
        rst_n = 1'b1;
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp %b", bus.busy, 1'b0); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL idle_ack got %b exp %b", bus.ack, 4'b0000); end
    endtask

    task automatic test_single();
        set_op(0, 2'b10, 4'd2, 64'hFFFF_FFFF_1234_5678, 64'h0000_0000_1234_5678, '1, '0);
        bus.req = 4'b0001;
        step();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_exec got %b exp %b", bus.busy, 1'b1); end
        checks++; if (bus.gnt_id !== 2'd0) begin errors++; $display("FAIL single_gnt got %0d exp %0d", bus.gnt_id, 0); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL single_ack_exec got %b exp %b", bus.ack, 4'b0000); end
        checks++; if (bus.alu_op !== 4'd2) begin errors++; $display("FAIL single_alu_op got %0d exp %0d", bus.alu_op, 2); end
        checks++; if (bus.alu_a !== 64'hFFFF_FFFF_1234_5678) begin errors++; $display("FAIL single_alu_a got %h exp %h", bus.alu_a, 64'hFFFF_FFFF_1234_5678); end
        step();
        checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL single_ack got %b exp %b", bus.ack, 4'b0001); end
        checks++; if (bus.res !== 64'd1) begin errors++; $display("FAIL single_res got %h exp %h", bus.res, 64'd1); end
        checks++; if (bus.flags !== 8'h82) begin errors++; $display("FAIL single_flags got %h exp %h", bus.flags, 8'h82); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_ack got %b exp %b", bus.busy, 1'b1); end
        checks++; if (bus.alu_op !== 4'd0) begin errors++; $display("FAIL single_alu_op_ack got %0d exp %0d", bus.alu_op, 0); end
        checks++; if (bus.alu_a !== 64'hFFFF_FFFF_1234_5678) begin errors++; $display("FAIL single_alu_a_hold got %h exp %h", bus.alu_a, 64'hFFFF_FFFF_1234_5678); end
        bus.req = 4'b0000;
        step();
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL single_ack_clear got %b exp %b", bus.ack, 4'b0000); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b exp %b", bus.busy, 1'b0); end
        checks++; if (bus.res !== 64'd1) begin errors++; $display("FAIL single_res_held got %h exp %h", bus.res, 64'd1); end
    endtask

    task automatic test_round_robin();
        int          exp_id  [5] = '{1, 2, 3, 0, 1};
        logic [63:0] exp_res [5] = '{64'd0, 64'd1, 64'd0, 64'd1, 64'd0};
        logic [3:0]  oh;
        logic [7:0]  ef;
        set_op(0, 2'b00, 4'd3, 64'h1,   64'h2,  '0, '0);
        set_op(1, 2'b00, 4'd3, 64'h5,   64'h3,  '0, '0);
        set_op(2, 2'b00, 4'd3, 64'h10,  64'h11, '0, '0);
        set_op(3, 2'b00, 4'd3, 64'h1FF, 64'h02, '0, '0);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << exp_id[k];
            ef = (exp_res[k] != 64'd0) ? 8'h83 : 8'h03;
            step();
            checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL rr_ack_exec[%0d] got %b exp %b", k, bus.ack, 4'b0000); end
            step();
            checks++; if (bus.ack !== oh) begin errors++; $display("FAIL rr_ack[%0d] got %b exp %b", k, bus.ack, oh); end
            checks++; if (bus.gnt_id !== IW'(exp_id[k])) begin errors++; $display("FAIL rr_gnt[%0d] got %0d exp %0d", k, bus.gnt_id, exp_id[k]); end
            checks++; if (bus.res !== exp_res[k]) begin errors++; $display("FAIL rr_res[%0d] got %h exp %h", k, bus.res, exp_res[k]); end
            checks++; if (bus.flags !== ef) begin errors++; $display("FAIL rr_flags[%0d] got %h exp %h", k, bus.flags, ef); end
            step();
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d] got %b exp %b", k, bus.busy, 1'b0); end
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_priority();
        bus.req = 4'b0001;
        step();
        step();
        checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL prio_pre_ack got %b exp %b", bus.ack, 4'b0001); end
        bus.req = 4'b0000;
        step();
        set_op(2, 2'b00, 4'd1, 64'h0F, 64'h0, 64'hF0, 64'h0F);
        set_op(0, 2'b00, 4'd1, 64'h1F, 64'h0, 64'hF0, 64'h0F);
        bus.req = 4'b0101;
        step();
        checks++; if (bus.gnt_id !== 2'd2) begin errors++; $display("FAIL prio_first_gnt got %0d exp %0d", bus.gnt_id, 2); end
        step();
        checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL prio_first_ack got %b exp %b", bus.ack, 4'b0100); end
        checks++; if (bus.res !== 64'd1) begin errors++; $display("FAIL mask_res_pass got %h exp %h", bus.res, 64'd1); end
        checks++; if (bus.flags !== 8'h81) begin errors++; $display("FAIL mask_flags_pass got %h exp %h", bus.flags, 8'h81); end
        bus.req = 4'b0001;
        step();
        step();
        checks++; if (bus.gnt_id !== 2'd0) begin errors++; $display("FAIL prio_second_gnt got %0d exp %0d", bus.gnt_id, 0); end
        step();
        checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL prio_second_ack got %b exp %b", bus.ack, 4'b0001); end
        checks++; if (bus.res !== 64'd0) begin errors++; $display("FAIL mask_res_fail got %h exp %h", bus.res, 64'd0); end
        checks++; if (bus.flags !== 8'h01) begin errors++; $display("FAIL mask_flags_fail got %h exp %h", bus.flags, 8'h01); end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_op_passthrough();
        set_op(1, 2'b00, 4'd5, 64'hFF, 64'h01, '1, '1);
        bus.req = 4'b0010;
        step();
        checks++; if (bus.alu_op !== 4'd5) begin errors++; $display("FAIL op5_alu_op got %0d exp %0d", bus.alu_op, 5); end
        checks++; if (bus.gnt_id !== 2'd1) begin errors++; $display("FAIL op5_gnt got %0d exp %0d", bus.gnt_id, 1); end
        step();
        checks++; if (bus.ack !== 4'b0010) begin errors++; $display("FAIL op5_ack got %b exp %b", bus.ack, 4'b0010); end
        checks++; if (bus.res !== 64'd0) begin errors++; $display("FAIL op5_res got %h exp %h", bus.res, 64'd0); end
        checks++; if (bus.flags !== 8'h00) begin errors++; $display("FAIL op5_flags got %h exp %h", bus.flags, 8'h00); end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_drop_early();
        set_op(3, 2'b00, 4'd3, 64'h1, 64'h2, '0, '0);
        bus.req = 4'b1000;
        step();
        bus.req = 4'b0000;
        step();
        checks++; if (bus.ack !== 4'b1000) begin errors++; $display("FAIL drop_ack got %b exp %b", bus.ack, 4'b1000); end
        checks++; if (bus.res !== 64'd1) begin errors++; $display("FAIL drop_res got %h exp %h", bus.res, 64'd1); end
        checks++; if (bus.flags !== 8'h83) begin errors++; $display("FAIL drop_flags got %h exp %h", bus.flags, 8'h83); end
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drop_idle got %b exp %b", bus.busy, 1'b0); end
    endtask

    task automatic test_reset_mid();
        set_op(2, 2'b01, 4'd3, 64'h1234, 64'h5678, '0, '0);
        bus.req = 4'b0100;
        step();
        checks++; if (bus.gnt_id !== 2'd2) begin errors++; $display("FAIL rstmid_gnt_pre got %0d exp %0d", bus.gnt_id, 2); end
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp %b", bus.busy, 1'b0); end
        checks++; if (bus.gnt_id !== 2'd0) begin errors++; $display("FAIL rstmid_gnt got %0d exp %0d", bus.gnt_id, 0); end
        checks++; if (bus.res !== 64'd0) begin errors++; $display("FAIL rstmid_res got %h exp %h", bus.res, 64'd0); end
        checks++; if (bus.flags !== 8'h00) begin errors++; $display("FAIL rstmid_flags got %h exp %h", bus.flags, 8'h00); end
        checks++; if (bus.alu_op !== 4'd0) begin errors++; $display("FAIL rstmid_alu_op got %0d exp %0d", bus.alu_op, 0); end
        checks++; if (bus.alu_a !== 64'd0) begin errors++; $display("FAIL rstmid_alu_a got %h exp %h", bus.alu_a, 64'd0); end
        checks++; if (bus.alu_size !== 2'd0) begin errors++; $display("FAIL rstmid_alu_size got %0d exp %0d", bus.alu_size, 0); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL rstmid_no_ack[%0d] got %b exp %b", k, bus.ack, 4'b0000); end
        end
        rst_n = 1'b1;
        step();
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL rstmid_no_ack_after got %b exp %b", bus.ack, 4'b0000); end
        set_op(0, 2'b00, 4'd3, 64'h1FF, 64'h02, '0, '0);
        set_op(3, 2'b00, 4'd3, 64'h7,   64'h9,  '0, '0);
        bus.req = 4'b1001;
        step();
        checks++; if (bus.gnt_id !== 2'd0) begin errors++; $display("FAIL post_rst_first_gnt got %0d exp %0d", bus.gnt_id, 0); end
        step();
        checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL post_rst_ack0 got %b exp %b", bus.ack, 4'b0001); end
        checks++; if (bus.res !== 64'd0) begin errors++; $display("FAIL low8_res got %h exp %h", bus.res, 64'd0); end
        checks++; if (bus.flags !== 8'h03) begin errors++; $display("FAIL low8_flags got %h exp %h", bus.flags, 8'h03); end
        bus.req = 4'b1000;
        step();
        step();
        checks++; if (bus.gnt_id !== 2'd3) begin errors++; $display("FAIL post_rst_gnt3 got %0d exp %0d", bus.gnt_id, 3); end
        step();
        checks++; if (bus.ack !== 4'b1000) begin errors++; $display("FAIL post_rst_ack3 got %b exp %b", bus.ack, 4'b1000); end
        checks++; if (bus.res !== 64'd1) begin errors++; $display("FAIL post_rst_res3 got %h exp %h", bus.res, 64'd1); end
        bus.req = 4'b0000;
        step();
    endtask

    initial begin
        bus.req      = '0;
        bus.req_size = '0;
        bus.req_op   = '0;
        bus.req_a    = '0;
        bus.req_b    = '0;
        bus.req_m0   = '0;
        bus.req_m1   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_op_passthrough();
        test_drop_early();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
